// File: rtl/shifter_pkg.sv
// Shared types for the operand2 decode stage: the shift opcodes, the decoded entry carried
// through the skid buffer, and the buffer occupancy states.
package shifter_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned AmtWidth  = 5;

  typedef enum logic [1:0] {
    ShiftLsl = 2'd0,
    ShiftLsr = 2'd1,
    ShiftAsr = 2'd2,
    ShiftRor = 2'd3
  } shift_op_e;

  typedef struct packed {
    logic [DataWidth-1:0] shift_in;
    logic [AmtWidth-1:0]  amount;
    shift_op_e            op;
    logic                 carry;
    logic                 bypass;
    logic [DataWidth-1:0] bypass_out;
    logic                 bypass_carry;
    logic                 err;
  } shift_entry_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } buf_state_e;

  // Entry whose result is fully resolved here and skips the barrel shifter.
  function automatic shift_entry_t make_bypass(input shift_entry_t base,
                                               input logic [DataWidth-1:0] value,
                                               input logic carry_out);
    shift_entry_t e;
    e              = base;
    e.bypass       = 1'b1;
    e.bypass_out   = value;
    e.bypass_carry = carry_out;
    return e;
  endfunction

endpackage

// File: rtl/shifter_operand_calc.sv
// Combinational decode of ARM operand2 into barrel-shifter controls, resolving the cases the
// 5-bit shifter cannot express (register amounts of 0 or >=32) into a bypass result.
module shifter_operand_calc
  import shifter_pkg::*;
(
  input  logic                 imm_flag,
  input  logic [11:0]          operand2,
  input  logic [DataWidth-1:0] rm_data,
  input  logic [7:0]           rs_amt,
  input  logic                 c_flag,
  output shift_entry_t         entry
);

  logic [3:0]           rot;
  logic [7:0]           imm8;
  shift_op_e            reg_op;
  logic                 amt_is_zero;
  logic                 amt_is_32;
  logic                 amt_over_32;
  logic                 rm_msb;
  logic [DataWidth-1:0] sign_fill;
  shift_entry_t         base;

  assign rot         = operand2[11:8];
  assign imm8        = operand2[7:0];
  assign reg_op      = shift_op_e'(operand2[6:5]);
  assign amt_is_zero = (rs_amt == 8'd0);
  assign amt_is_32   = (rs_amt == 8'd32);
  assign amt_over_32 = (rs_amt > 8'd32);
  assign rm_msb      = rm_data[DataWidth-1];
  assign sign_fill   = {DataWidth{rm_msb}};

  always_comb begin
    base          = '0;
    base.carry    = c_flag;
    base.shift_in = rm_data;
    base.op       = reg_op;
    base.amount   = rs_amt[AmtWidth-1:0];
    entry         = base;

    if (imm_flag) begin
      entry.shift_in = {{(DataWidth-8){1'b0}}, imm8};
      entry.op       = ShiftRor;
      entry.amount   = {rot, 1'b0};
      if (rot == 4'd0) begin
        entry = make_bypass(entry, {{(DataWidth-8){1'b0}}, imm8}, c_flag);
      end
    end else if (!operand2[4]) begin
      entry.amount = operand2[11:7];
    end else if (operand2[7]) begin
      // Multiply / extra load-store space: pass Rm through untouched and flag it.
      entry     = make_bypass(base, rm_data, c_flag);
      entry.err = 1'b1;
    end else if (amt_is_zero) begin
      entry = make_bypass(base, rm_data, c_flag);
    end else begin
      unique case (reg_op)
        ShiftLsl: begin
          if (amt_is_32) begin
            entry = make_bypass(base, '0, rm_data[0]);
          end else if (amt_over_32) begin
            entry = make_bypass(base, '0, 1'b0);
          end
        end
        ShiftLsr: begin
          if (amt_is_32) begin
            entry = make_bypass(base, '0, rm_msb);
          end else if (amt_over_32) begin
            entry = make_bypass(base, '0, 1'b0);
          end
        end
        ShiftAsr: begin
          if (amt_is_32 || amt_over_32) begin
            entry = make_bypass(base, sign_fill, rm_msb);
          end
        end
        ShiftRor: begin
          // Non-zero multiple of 32 rotates back to Rm but still updates carry.
          if (rs_amt[AmtWidth-1:0] == '0) begin
            entry = make_bypass(base, rm_data, rm_msb);
          end
        end
        default: entry = base;
      endcase
    end
  end

endmodule

// File: rtl/shifter_operand_decode.sv
// Operand2 decode stage feeding barrel_shift_arm; decoded entries are registered behind a
// two-entry valid/ready skid buffer (head drives the outputs, skid catches a stalled accept).
module shifter_operand_decode
  import shifter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  imm_flag,
  input  logic [11:0]           operand2,
  input  logic [DATA_WIDTH-1:0] rm_data,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic                  c_flag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] shift_in,
  output logic [ADDR_WIDTH-1:0] shift_amount,
  output logic [1:0]            shift_op,
  output logic                  carry_flag,
  output logic                  bypass,
  output logic [DATA_WIDTH-1:0] bypass_out,
  output logic                  bypass_carry,
  output logic                  decode_err
);

  buf_state_e   state_q, state_d;
  shift_entry_t calc_entry;
  shift_entry_t head_q;
  shift_entry_t skid_q;
  logic         accept;
  logic         pop;
  logic         load_head;
  logic         load_skid;
  logic         head_from_skid;
  logic         unused_rs_hi;

  // Only the low byte of Rs carries a shift amount.
  assign unused_rs_hi = ^rs_data[DATA_WIDTH-1:8];

  shifter_operand_calc u_calc (
    .imm_flag (imm_flag),
    .operand2 (operand2),
    .rm_data  (rm_data),
    .rs_amt   (rs_data[7:0]),
    .c_flag   (c_flag),
    .entry    (calc_entry)
  );

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush wins over a same-cycle accept.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (accept) state_d = StOne;
        StOne: begin
          if (accept && !pop) begin
            state_d = StFull;
          end else if (!accept && pop) begin
            state_d = StEmpty;
          end
        end
        StFull:  if (pop) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  // Handshake outputs; in_ready is held low while reset is asserted.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StEmpty: in_ready = !rst;
      StOne: begin
        in_ready  = !rst;
        out_valid = 1'b1;
      end
      StFull:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  assign load_head      = accept & ((state_q == StEmpty) | ((state_q == StOne) & pop));
  assign load_skid      = accept & (state_q == StOne) & ~pop;
  assign head_from_skid = (state_q == StFull) & pop;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (head_from_skid) begin
        head_q <= skid_q;
      end else if (load_head) begin
        head_q <= calc_entry;
      end
      if (load_skid) begin
        skid_q <= calc_entry;
      end
    end
  end

  assign shift_in     = head_q.shift_in;
  assign shift_amount = head_q.amount;
  assign shift_op     = head_q.op;
  assign carry_flag   = head_q.carry;
  assign bypass       = head_q.bypass;
  assign bypass_out   = head_q.bypass_out;
  assign bypass_carry = head_q.bypass_carry;
  assign decode_err   = head_q.err;

endmodule
